// File: rtl/tape_pkg.sv
// -----------------------------------------------------------------------------
// tape_pkg
// Types and constants shared by the tape RAM arbiter, its write FIFO and the
// cassette loader.
//   tape_state_e         : arbiter FSM encoding
//   tape_wr_t            : one queued loader write {addr, data}
//   LYNX_BASIC_LOAD_ADDR : default BASIC load address used by the loader
// -----------------------------------------------------------------------------
package tape_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RELEASE = 3'd4
  } tape_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } tape_wr_t;

  localparam logic [15:0] LYNX_BASIC_LOAD_ADDR = 16'h694D;

endpackage

// File: rtl/tape_wr_fifo.sv
// -----------------------------------------------------------------------------
// tape_wr_fifo
// Synchronous show-ahead FIFO holding loader writes until the RAM port is free.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_wdata: enqueue one entry; ignored when full unless popping
//   i_pop          : dequeue head entry; ignored when empty
//   o_rdata        : head entry (valid while !o_empty)
//   o_full, o_empty, o_count : occupancy
// -----------------------------------------------------------------------------
module tape_wr_fifo
  import tape_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  tape_wr_t      i_wdata,
  input  logic          i_pop,
  output tape_wr_t      o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  tape_wr_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_do_pop;
  logic            w_do_push;

  assign o_full   = (r_count == CNT_MAX);
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rdata  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push that coincides with a pop.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tape_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tape_ram_arbiter
// Shares the main-RAM write port between the Z80 and the cassette loader.
// Loader writes are queued and drained whenever the CPU is off the bus; the
// CPU is held in WAIT during a download, and once the stream has finished and
// the queue is empty the captured execution address is pulsed out.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   ioctl_download                   : tape image download in progress
//   tape_wr/addr/dout/complete       : loader write stream + completion strobe
//   cpu_addr/dout/mreq_n/wr_n        : CPU memory bus
//   cpu_wait_n                       : CPU WAIT (active low)
//   ram_addr/din/we                  : registered RAM write port
//   exec_addr, exec_valid            : execution address + one-cycle strobe
//   fifo_ovf                         : sticky, a loader write was dropped
//   busy                             : FSM not idle
// The queued entry carries a 16-bit address, so ADDR_W is expected to be 16.
// -----------------------------------------------------------------------------
module tape_ram_arbiter
  import tape_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              tape_wr,
  input  logic [ADDR_W-1:0] tape_addr,
  input  logic [7:0]        tape_dout,
  input  logic              tape_complete,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_mreq_n,
  input  logic              cpu_wr_n,
  output logic              cpu_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic [ADDR_W-1:0] exec_addr,
  output logic              exec_valid,
  output logic              fifo_ovf,
  output logic              busy
);

  tape_state_e        r_state, w_state_nxt;
  logic               r_wait_n, w_wait_n_nxt;

  logic               r_prev_wr;
  logic [ADDR_W-1:0]  r_prev_addr;

  logic [ADDR_W-1:0]  r_ram_addr;
  logic [7:0]         r_ram_din;
  logic               r_ram_we;

  logic [ADDR_W-1:0]  r_exec_addr;
  logic               r_exec_pending;
  logic               r_fifo_ovf;

  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  tape_wr_t           w_wdata;
  tape_wr_t           w_rdata;
  logic               w_full;
  logic               w_empty;
  logic [FIFO_AW:0]   w_count;

  // The loader holds tape_wr high across consecutive bytes, so a new byte is
  // recognised by a rising tape_wr or an address change.
  assign w_push  = tape_wr && (!r_prev_wr || (tape_addr != r_prev_addr));
  assign w_wdata = '{addr: tape_addr, data: tape_dout};

  // CPU has absolute priority; the queue only drains on idle bus cycles.
  assign w_pop   = cpu_mreq_n && !w_empty;
  assign w_drop  = w_push && w_full && !w_pop;

  tape_wr_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_n_nxt = r_wait_n;
    case (r_state)
      ST_IDLE: begin
        w_wait_n_nxt = 1'b1;
        if (ioctl_download) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // Only assert WAIT once the bus is idle, so a running CPU cycle
        // completes untouched; WAIT then stays low until RELEASE.
        if (cpu_mreq_n) w_wait_n_nxt = 1'b0;
        if (!ioctl_download) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A push landing this cycle would leave the queue non-empty.
        if ((w_count == '0) && !w_push)
          w_state_nxt = r_exec_pending ? ST_EXEC : ST_RELEASE;
      end
      ST_EXEC: begin
        w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_wait_n_nxt = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_wait_n_nxt = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_wait_n <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_wait_n <= w_wait_n_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Write detection history, exec address capture, overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_wr      <= 1'b0;
      r_prev_addr    <= '0;
      r_exec_addr    <= '0;
      r_exec_pending <= 1'b0;
      r_fifo_ovf     <= 1'b0;
    end else begin
      r_prev_wr   <= tape_wr;
      r_prev_addr <= tape_addr;
      if ((r_state == ST_HOLD) && tape_complete) begin
        r_exec_addr    <= tape_addr;
        r_exec_pending <= 1'b1;
      end else if (r_state == ST_EXEC) begin
        r_exec_pending <= 1'b0;
      end
      if (w_drop) r_fifo_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered RAM port mux
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
    end else if (!cpu_mreq_n) begin
      r_ram_addr <= cpu_addr;
      r_ram_din  <= cpu_dout;
      r_ram_we   <= ~cpu_wr_n;
    end else if (!w_empty) begin
      r_ram_addr <= w_rdata.addr;
      r_ram_din  <= w_rdata.data;
      r_ram_we   <= 1'b1;
    end else begin
      r_ram_we   <= 1'b0;
    end
  end

  assign cpu_wait_n = r_wait_n;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign ram_we     = r_ram_we;
  assign exec_addr  = r_exec_addr;
  assign exec_valid = (r_state == ST_EXEC);
  assign fifo_ovf   = r_fifo_ovf;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/tape_ram_arbiter.md
Name: tape_ram_arbiter

Overview:
Shares the single main-RAM write port between the Z80 CPU and the cassette loader's byte-write stream (tape_wr/tape_addr/tape_dout/tape_complete). Loader writes go into a small FIFO and are drained to RAM whenever the CPU is not using memory. While a tape download is active, the CPU is stalled with WAIT. Once the stream completes and the FIFO is empty, the block publishes the captured execution address as a one-cycle pulse to the boot/jump logic.

Parameters:
FIFO_AW, 2, log2 of write-FIFO depth (depth = 2**FIFO_AW = 4 entries).
ADDR_W, 16, RAM/CPU address width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ioctl_download  in  1  high while a tape image is being downloaded
tape_wr  in  1  loader write-enable (level; stays high across consecutive bytes)
tape_addr  in  ADDR_W  loader write address; carries exec address on tape_complete
tape_dout  in  8  loader write data
tape_complete  in  1  loader completion strobe
cpu_addr  in  ADDR_W  CPU address
cpu_dout  in  8  CPU write data
cpu_mreq_n  in  1  CPU memory request, active low
cpu_wr_n  in  1  CPU write strobe, active low
cpu_wait_n  out  1  CPU WAIT, active low
ram_addr  out  ADDR_W  RAM address
ram_din  out  8  RAM write data
ram_we  out  1  RAM write enable
exec_addr  out  ADDR_W  captured execution address
exec_valid  out  1  one-cycle pulse: exec_addr is valid
fifo_ovf  out  1  sticky FIFO-overflow flag
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, synchronous and dominant over all inputs:
  - FSM=IDLE; FIFO emptied.
  - cpu_wait_n=1; ram_we=0; ram_addr=0; ram_din=0.
  - exec_addr=0; exec_valid=0; fifo_ovf=0; busy=0.
  - Reset mid-download discards queued writes and releases WAIT in the same edge.
- New-write detection, registered copies of tape_wr/tape_addr:
  - A write is pushed when tape_wr=1 and either the previous tape_wr was 0, or tape_addr differs from its previous value.
  - A steady tape_wr=1 with an unchanged address pushes nothing.
- FIFO:
  - Each entry is {addr, data}.
  - If a push arrives while the FIFO is full, the entry is dropped and fifo_ovf is set, cleared only by reset.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- RAM port mux, registered, 1-cycle latency from grant to ram_we:
  - CPU owns the port when cpu_mreq_n=0: ram_addr=cpu_addr, ram_din=cpu_dout, ram_we=~cpu_wr_n.
  - Otherwise, if the FIFO is non-empty, pop one entry and drive it with ram_we=1 for exactly one cycle.
  - Priority on simultaneous request: CPU wins, FIFO waits.
- FSM:
  - IDLE:
    - On ioctl_download=1 -> HOLD.
  - HOLD:
    - cpu_wait_n goes 0 at the first cycle in which cpu_mreq_n=1 is sampled; an in-flight CPU cycle is never cut.
    - Drain the FIFO every cycle (the CPU is stalled).
    - tape_complete=1 latches tape_addr into exec_addr and sets an internal exec_pending.
    - On ioctl_download=0 -> DRAIN.
  - DRAIN:
    - Continue popping.
    - When the FIFO is empty: -> EXEC if exec_pending, else -> RELEASE.
  - EXEC:
    - exec_valid=1 for one cycle; clear exec_pending; -> RELEASE.
  - RELEASE:
    - cpu_wait_n=1; -> IDLE.
- tape_complete and a push in the same cycle: both take effect.
- tape_complete outside HOLD is ignored.
- ioctl_download re-asserting during DRAIN/EXEC/RELEASE is served only after the FSM returns to IDLE (next cycle).
- exec_valid never asserts while the FIFO is non-empty.

Decomposition:
- Shared package tape_pkg holds:
  - FSM state encoding (IDLE, HOLD, DRAIN, EXEC, RELEASE).
  - FIFO entry struct {addr[15:0], data[7:0]}.
  - Lynx default BASIC load address constant 16'h694D, shared with the cassette loader.
- One natural sub-module, tape_wr_fifo: a synchronous FIFO (depth 2**FIFO_AW) with push/pop/full/empty/count.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. Reset mid-HOLD with 3 queued writes -> next cycle cpu_wait_n=1, ram_we=0, FIFO empty, busy=0.
2. Download starts while the CPU holds cpu_mreq_n=0 for 3 cycles -> cpu_wait_n stays 1 until mreq_n returns high, then 0 next edge; no ram_we from the FIFO during CPU-owned cycles.
3. Stream tape_wr=1 with addr 694D..6950 and data 11,22,33,44, tape_wr held high -> exactly 4 RAM writes, each ram_we=1 for one cycle, correct addr/data; a repeated address with no change produces no extra write.
4. tape_complete with tape_addr=16'h0CC1, then download ends with 2 entries queued -> both RAM writes occur, then exec_valid=1 for exactly one cycle with exec_addr=0CC1, then cpu_wait_n=1.
5. 5 pushes with pops blocked by cpu_mreq_n=0 (IDLE) -> 4 stored, fifth dropped, fifo_ovf=1 and stays 1 until reset.
6. Download with no tape_complete -> DRAIN goes straight to RELEASE; exec_valid never asserts.
